// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - main-memory line responder for data-cache refills and writebacks (optional LINE_ALIGN_CHECK_EN)
module line_memory_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 20,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [511:0] req_wdata,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [511:0] resp_rdata,
    output logic         resp_err,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int             CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [511:0]     wdata_q, wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [511:0]     resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [511:0] mem [DEPTH_LINES];

    logic             accept;
    logic             enter_resp;
    logic             op_write;
    logic [31:0]      op_addr;
    logic [511:0]     op_wdata;
    logic [IDX_W-1:0] op_idx;
    logic             op_misaligned;
    logic             unused_addr_bits;

    assign accept = (state_q == S_IDLE) && req_valid;

    // With LATENCY==1 the request completes on its acceptance edge, so the
    // operation must come straight from the inputs rather than the latches.
    assign op_write = (state_q == S_IDLE) ? req_write : wr_q;
    assign op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign op_idx   = op_addr[6+IDX_W-1:6];

    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == CNT_ONE));

`ifdef LINE_ALIGN_CHECK_EN
    assign op_misaligned = (op_addr[5:0] != 6'd0);
`else
    assign op_misaligned = 1'b0;
`endif

    // Upper address bits alias the line space; low bits only matter for the check.
    assign unused_addr_bits = ^{op_addr[31:6+IDX_W], op_addr[5:0]};

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Next-state logic: request latching, latency countdown and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            resp_err_d   = op_misaligned;
            if (!op_write) begin
                resp_rdata_d = mem[op_idx];
            end
        end
    end

    // Control and response registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Line storage survives reset; a write commits only when it completes.
    always_ff @(posedge clk) begin
        if (enter_resp && op_write && !op_misaligned) begin
            mem[op_idx] <= op_wdata;
        end
    end

endmodule
